// File: rtl/lcg_stream_checker.sv
// Checks an incoming word stream against a 32-bit LCG sequence and
// records the error count plus the first mismatch of each run.
module lcg_stream_checker #(
  parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC = 32'h00003039,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [31:0]      first_err_exp,
  output logic [31:0]      first_err_got
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      expected;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] last_idx;
  logic             start_ok;
  logic             accept;
  logic             mismatch;
  logic             last_word;

  function automatic logic [31:0] lcg_next(input logic [31:0] x);
    return x * LCG_MUL + LCG_INC;
  endfunction

  assign start_ok  = start && (state != RUN);
  assign accept    = in_valid && (state == RUN);
  assign mismatch  = accept && (in_data != expected);
  assign last_word = accept && (idx == last_idx);

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign pass     = (state == DONE) && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = (num_words == '0) ? DONE : RUN;
      RUN:        if (last_word) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The seed itself is never compared: the first expected word is next(seed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected      <= '0;
      idx           <= '0;
      last_idx      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start_ok) begin
      expected      <= lcg_next(seed);
      idx           <= '0;
      last_idx      <= num_words - CNT_W'(1);
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (accept) begin
      expected <= lcg_next(expected);
      idx      <= idx + CNT_W'(1);
      if (mismatch) begin
        // err_count saturates, so zero reliably marks "no mismatch yet".
        if (err_count == '0) begin
          first_err_idx <= idx;
          first_err_exp <= expected;
          first_err_got <= in_data;
        end
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/lcg_stream_checker.md
LCG_STREAM_CHECKER -- requirements
Module: lcg_stream_checker

Interface
REQ-001 Parameter LCG_MUL, default 32'h41C64E6D: LCG multiplier.
REQ-002 Parameter LCG_INC, default 32'h00003039: LCG increment.
REQ-003 Parameter CNT_W, default 32: width of the word-count, index and error-count fields.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a check run.
REQ-007 seed  in  32  LCG seed, sampled on an accepted start.
REQ-008 num_words  in  CNT_W  words to check, sampled on an accepted start.
REQ-009 in_valid  in  1  in_data carries a word this cycle.
REQ-010 in_data  in  32  received stream word.
REQ-011 in_ready  out  1  checker accepts in_data this cycle.
REQ-012 busy  out  1  run in progress.
REQ-013 done  out  1  run complete; held until the next accepted start.
REQ-014 pass  out  1  done with zero mismatches.
REQ-015 err_count  out  CNT_W  mismatches in the current or last run, saturating.
REQ-016 first_err_idx  out  CNT_W  word index of the first mismatch.
REQ-017 first_err_exp / first_err_got  out  32 each  expected and received word at the first mismatch.

Function
REQ-018 FSM states: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on start with num_words != 0.
- IDLE/DONE -> DONE on start with num_words == 0; pass=1 and err_count=0 on the next cycle.
- RUN -> DONE on acceptance of word num_words-1.
REQ-019 Expected-word recurrence: next(x) = (x*LCG_MUL + LCG_INC) mod 2^32.
- On an accepted start, the expected register loads next(seed), so the first seed value itself is never compared.
REQ-020 An accepted start clears err_count, first_err_* and the word index, and deasserts done and pass in the following cycle.
REQ-021 start is ignored while in RUN.
REQ-022 in_ready is 1 exactly when the state is RUN; a word is accepted when in_valid && in_ready.
REQ-023 in_data is ignored outside RUN.
REQ-024 Per accepted word:
- compare in_data with the expected register;
- advance expected to next(expected);
- increment the index.
- Compare and update happen in the same cycle, with zero latency to registered outputs (visible on the next cycle).
REQ-025 On a mismatch, err_count increments, saturating at all-ones.
REQ-026 On the first mismatch of a run only, capture first_err_idx, first_err_exp and first_err_got; later mismatches leave these unchanged.
REQ-027 in_valid low in RUN: expected register, index and all outputs hold.
REQ-028 busy = (state==RUN).
- done = (state==DONE).
- pass = done && err_count==0.
- All outputs are registered or decoded directly from state.
REQ-029 The index counter wraps modulo 2^CNT_W; a run with num_words = 2^CNT_W-1 completes normally.
REQ-030 An accepted word is still compared on the same cycle the FSM transitions to DONE.

Reset
REQ-031 rst high forces, asynchronously:
- state=IDLE;
- in_ready=0, busy=0, done=0, pass=0;
- err_count=0, first_err_idx=0, first_err_exp=0, first_err_got=0;
- expected register=0, index=0.
REQ-032 rst asserted mid-run abandons the run; no partial done or pass is reported.
REQ-033 After rst deasserts, the block stays in IDLE until the first start.

Verification
REQ-034 The bench shall cover these directed scenarios:
- seed=0, num_words=2, words 0x00003039 then 0xD3DC167E, in_valid continuous -> done=1, pass=1, err_count=0, two cycles after the first acceptance.
- seed=0, num_words=2, second word 0xD3DC167F -> done=1, pass=0, err_count=1, first_err_idx=1, first_err_exp=0xD3DC167E, first_err_got=0xD3DC167F.
- seed=1461364854, num_words=100, model-generated words with random in_valid gaps -> pass=1; in_ready=0 after done.
- start with num_words=0 -> DONE next cycle, pass=1, in_ready never 1.
- Three corrupted words at indices 3, 7, 9 -> err_count=3, first_err_idx=3.
- rst pulse at word 5 of 10 -> all outputs 0 and IDLE; a fresh start afterwards passes.
- Second start while busy -> ignored; the run result is unchanged.
